// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared fetch-core types and constants (FSM encoding,
//               instruction length, NOP encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    // Fetch FSM: whether a read is outstanding and whether its data is kept
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } fetchState_t;

    // Byte distance between consecutive instructions
    localparam int ILEN_BYTES = 4;

    // Encoding decode substitutes when no instruction is available
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bundles the redirect, instruction-memory and decode-side
//               handshakes of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
    parameter int PC_W = 8
);
    // Redirect from the branch resolver
    logic            iBR_TAKEN;
    logic [31:0]     iPCBR;
    // Instruction memory read port
    logic            oIMEM_REQ;
    logic [PC_W-1:0] oIMEM_ADDR;
    logic            iIMEM_ACK;
    logic [31:0]     iIMEM_RDATA;
    // Decode-side instruction handshake
    logic            oIR_VALID;
    logic [31:0]     oIR;
    logic [PC_W-1:0] oIR_PC;
    logic            iIR_READY;

    // Fetch unit side
    modport master (
        input  iBR_TAKEN, iPCBR, iIMEM_ACK, iIMEM_RDATA, iIR_READY,
        output oIMEM_REQ, oIMEM_ADDR, oIR_VALID, oIR, oIR_PC
    );

    // Surrounding pipeline / memory side
    modport slave (
        output iBR_TAKEN, iPCBR, iIMEM_ACK, iIMEM_RDATA, iIR_READY,
        input  oIMEM_REQ, oIMEM_ADDR, oIR_VALID, oIR, oIR_PC
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Small circular instruction buffer with synchronous clear.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 40,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata,
    output logic      [CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPop;
    logic             w_doPush;

    // A push at full is only accepted when the head leaves in the same cycle
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    assign count = r_count;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign rdata = r_mem[r_rdPtr];

    // Pointer and occupancy bookkeeping; clear wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; reset to zero so the head reads as zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_doPush && !clear) begin
            r_mem[r_wrPtr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Front-end fetch unit. Owns the PC, issues single outstanding
//               word reads, buffers returned words for decode and handles
//               redirects from the branch resolver.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  wire logic            iCLK,
    input  wire logic            iRST_N,
    instruction_fetch_if.master  bus
);

    localparam int ENT_W = 32 + PC_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0] c_resetPc = {RESET_PC[PC_W-1:2], 2'b00};

    fetchState_t      r_state;
    fetchState_t      w_stateNext;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pcNext;
    logic [PC_W-1:0]  r_dropAddr;
    logic [PC_W-1:0]  w_dropAddrNext;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_addr;
    logic             w_req;
    logic             w_accept;
    logic             w_clear;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;

    // Redirect target is word-aligned; bits above the PC width are ignored
    assign w_target = {bus.iPCBR[PC_W-1:2], 2'b00};

    // While draining a discarded read the old address must stay on the bus
    assign w_addr = (r_state == S_DROP) ? r_dropAddr : r_pc;

    assign w_pop  = !w_empty && bus.iIR_READY && !bus.iBR_TAKEN;
    assign w_push = w_accept && (!w_full || w_pop);

    assign bus.oIMEM_REQ  = w_req;
    assign bus.oIMEM_ADDR = w_addr;
    assign bus.oIR_VALID  = !w_empty;
    assign bus.oIR        = w_head[ENT_W-1:PC_W];
    assign bus.oIR_PC     = w_head[PC_W-1:0];

    // State, fetch PC and discarded-read address registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= S_FETCH;
            r_pc       <= c_resetPc;
            r_dropAddr <= c_resetPc;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_dropAddr <= w_dropAddrNext;
        end
    end

    // Request generation, response acceptance, PC update and redirect handling
    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_dropAddrNext = r_dropAddr;
        w_req          = 1'b0;
        w_accept       = 1'b0;
        w_clear        = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Reset gating keeps the request low while reset is held
                w_req    = iRST_N && (w_count < CNT_W'(DEPTH)) && !bus.iBR_TAKEN;
                w_accept = w_req && bus.iIMEM_ACK;
                if (w_req && !bus.iIMEM_ACK) w_stateNext = S_WAIT;
            end
            S_WAIT: begin
                w_req    = 1'b1;
                w_accept = bus.iIMEM_ACK;
                if (bus.iIMEM_ACK) w_stateNext = S_FETCH;
            end
            S_DROP: begin
                w_req = 1'b1;
                if (bus.iIMEM_ACK) w_stateNext = S_FETCH;
            end
            default: begin
                w_stateNext = S_FETCH;
            end
        endcase

        if (w_accept) w_pcNext = r_pc + PC_W'(ILEN_BYTES);

        // Redirect overrides every other update; an unanswered read is drained
        if (bus.iBR_TAKEN) begin
            w_clear  = 1'b1;
            w_accept = 1'b0;
            w_pcNext = w_target;
            if ((r_state == S_WAIT) && !bus.iIMEM_ACK) begin
                w_stateNext    = S_DROP;
                w_dropAddrNext = r_pc;
            end else if ((r_state == S_DROP) && !bus.iIMEM_ACK) begin
                w_stateNext = S_DROP;
            end else begin
                w_stateNext = S_FETCH;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .clear (w_clear),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({bus.iIMEM_RDATA, w_addr}),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch
//               (PC_W = 8, RESET_PC = 0, DEPTH = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int PC_W = 8;

    logic clk    = 1'b0;
    logic rstN   = 1'b0;
    logic useNop = 1'b0;
    int   nTests = 0;
    int   nFail  = 0;

    instruction_fetch_if #(.PC_W(PC_W)) bus ();

    instruction_fetch #(
        .PC_W     (PC_W),
        .RESET_PC (8'h00),
        .DEPTH    (2)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Memory data: NOP, or a word tagged with its own address
    assign bus.iIMEM_RDATA = useNop ? NOP_INSN : {24'hC0DE00, bus.oIMEM_ADDR};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        bus.iBR_TAKEN = 1'b0;
        bus.iPCBR     = 32'h0;
        bus.iIMEM_ACK = 1'b0;
        bus.iIR_READY = 1'b0;
        useNop        = 1'b0;
        rstN          = 1'b0;
        tick();
        rstN = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.iBR_TAKEN = 1'b0;
        bus.iPCBR     = 32'h0;
        bus.iIMEM_ACK = 1'b0;
        bus.iIR_READY = 1'b0;
        rstN          = 1'b0;
        tick();
        tick();
        nTests++; if (bus.oIMEM_REQ !== 1'b0) begin nFail++; $display("FAIL reset_req: got %b expected 0", bus.oIMEM_REQ); end
        nTests++; if (bus.oIMEM_ADDR !== 8'h00) begin nFail++; $display("FAIL reset_addr: got %h expected 00", bus.oIMEM_ADDR); end
        nTests++; if (bus.oIR_VALID !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b expected 0", bus.oIR_VALID); end
        nTests++; if (bus.oIR !== 32'h0) begin nFail++; $display("FAIL reset_ir: got %h expected 0", bus.oIR); end
        nTests++; if (bus.oIR_PC !== 8'h00) begin nFail++; $display("FAIL reset_irpc: got %h expected 00", bus.oIR_PC); end
        rstN = 1'b1;
        #1;
        nTests++; if (bus.oIMEM_REQ !== 1'b1) begin nFail++; $display("FAIL first_req: got %b expected 1", bus.oIMEM_REQ); end
        nTests++; if (bus.oIMEM_ADDR !== 8'h00) begin nFail++; $display("FAIL first_addr: got %h expected 00", bus.oIMEM_ADDR); end
    endtask

    task automatic test_stream();
        doReset();
        useNop        = 1'b1;
        bus.iIMEM_ACK = 1'b1;
        bus.iIR_READY = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            nTests++; if (bus.oIMEM_ADDR !== 8'(4 * k)) begin nFail++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, bus.oIMEM_ADDR, 8'(4 * k)); end
            tick();
            nTests++; if (bus.oIR_VALID !== 1'b1) begin nFail++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, bus.oIR_VALID); end
            nTests++; if (bus.oIR_PC !== 8'(4 * k)) begin nFail++; $display("FAIL stream_irpc[%0d]: got %h expected %h", k, bus.oIR_PC, 8'(4 * k)); end
            nTests++; if (bus.oIR !== 32'h0000_0013) begin nFail++; $display("FAIL stream_ir[%0d]: got %h expected 00000013", k, bus.oIR); end
        end
        bus.iIMEM_ACK = 1'b0;
        bus.iIR_READY = 1'b0;
        useNop        = 1'b0;
    endtask

    task automatic test_backpressure();
        doReset();
        bus.iIR_READY = 1'b0;
        bus.iIMEM_ACK = 1'b1;
        #1;
        tick();
        tick();
        nTests++; if (bus.oIMEM_REQ !== 1'b0) begin nFail++; $display("FAIL bp_full_req: got %b expected 0", bus.oIMEM_REQ); end
        nTests++; if (bus.oIMEM_ADDR !== 8'h08) begin nFail++; $display("FAIL bp_full_addr: got %h expected 08", bus.oIMEM_ADDR); end
        tick();
        nTests++; if (bus.oIMEM_REQ !== 1'b0) begin nFail++; $display("FAIL bp_hold_req: got %b expected 0", bus.oIMEM_REQ); end
        nTests++; if (bus.oIR_PC !== 8'h00) begin nFail++; $display("FAIL bp_hold_irpc: got %h expected 00", bus.oIR_PC); end
        nTests++; if (bus.oIR !== 32'hC0DE_0000) begin nFail++; $display("FAIL bp_hold_ir: got %h expected c0de0000", bus.oIR); end
        bus.iIR_READY = 1'b1;
        #1;
        tick();
        nTests++; if (bus.oIR_PC !== 8'h04) begin nFail++; $display("FAIL bp_pop_irpc: got %h expected 04", bus.oIR_PC); end
        nTests++; if (bus.oIMEM_REQ !== 1'b1) begin nFail++; $display("FAIL bp_resume_req: got %b expected 1", bus.oIMEM_REQ); end
        nTests++; if (bus.oIMEM_ADDR !== 8'h08) begin nFail++; $display("FAIL bp_resume_addr: got %h expected 08", bus.oIMEM_ADDR); end
        tick();
        nTests++; if (bus.oIR_PC !== 8'h08) begin nFail++; $display("FAIL bp_next_irpc: got %h expected 08", bus.oIR_PC); end
        nTests++; if (bus.oIR !== 32'hC0DE_0008) begin nFail++; $display("FAIL bp_next_ir: got %h expected c0de0008", bus.oIR); end
        bus.iIMEM_ACK = 1'b0;
        bus.iIR_READY = 1'b0;
    endtask

    task automatic test_redirect_wait();
        doReset();
        bus.iIR_READY = 1'b1;
        bus.iBR_TAKEN = 1'b1;
        bus.iPCBR     = 32'h10;
        #1;
        nTests++; if (bus.oIMEM_REQ !== 1'b0) begin nFail++; $display("FAIL rw_br_noreq: got %b expected 0", bus.oIMEM_REQ); end
        tick();
        bus.iBR_TAKEN = 1'b0;
        #1;
        nTests++; if (bus.oIMEM_ADDR !== 8'h10) begin nFail++; $display("FAIL rw_addr10: got %h expected 10", bus.oIMEM_ADDR); end
        tick();
        bus.iBR_TAKEN = 1'b1;
        bus.iPCBR     = 32'h40;
        #1;
        nTests++; if (bus.oIMEM_REQ !== 1'b1 || bus.oIMEM_ADDR !== 8'h10) begin nFail++; $display("FAIL rw_wait_hold: got req=%b addr=%h expected req=1 addr=10", bus.oIMEM_REQ, bus.oIMEM_ADDR); end
        tick();
        bus.iBR_TAKEN = 1'b0;
        #1;
        nTests++; if (bus.oIMEM_REQ !== 1'b1 || bus.oIMEM_ADDR !== 8'h10) begin nFail++; $display("FAIL rw_drop_hold: got req=%b addr=%h expected req=1 addr=10", bus.oIMEM_REQ, bus.oIMEM_ADDR); end
        tick();
        bus.iIMEM_ACK = 1'b1;
        tick();
        bus.iIMEM_ACK = 1'b0;
        #1;
        nTests++; if (bus.oIR_VALID !== 1'b0) begin nFail++; $display("FAIL rw_discard_valid: got %b expected 0", bus.oIR_VALID); end
        nTests++; if (bus.oIMEM_REQ !== 1'b1 || bus.oIMEM_ADDR !== 8'h40) begin nFail++; $display("FAIL rw_target_req: got req=%b addr=%h expected req=1 addr=40", bus.oIMEM_REQ, bus.oIMEM_ADDR); end
        bus.iIMEM_ACK = 1'b1;
        tick();
        nTests++; if (bus.oIR_VALID !== 1'b1 || bus.oIR_PC !== 8'h40) begin nFail++; $display("FAIL rw_first_irpc: got valid=%b pc=%h expected valid=1 pc=40", bus.oIR_VALID, bus.oIR_PC); end
        nTests++; if (bus.oIR !== 32'hC0DE_0040) begin nFail++; $display("FAIL rw_first_ir: got %h expected c0de0040", bus.oIR); end
        bus.iIMEM_ACK = 1'b0;
        bus.iIR_READY = 1'b0;
    endtask

    task automatic test_redirect_ack_pop();
        doReset();
        bus.iIMEM_ACK = 1'b1;
        #1;
        tick();
        bus.iIMEM_ACK = 1'b0;
        tick();
        nTests++; if (bus.oIR_VALID !== 1'b1 || bus.oIR_PC !== 8'h00) begin nFail++; $display("FAIL rap_setup_head: got valid=%b pc=%h expected valid=1 pc=00", bus.oIR_VALID, bus.oIR_PC); end
        nTests++; if (bus.oIMEM_REQ !== 1'b1 || bus.oIMEM_ADDR !== 8'h04) begin nFail++; $display("FAIL rap_setup_req: got req=%b addr=%h expected req=1 addr=04", bus.oIMEM_REQ, bus.oIMEM_ADDR); end
        bus.iIMEM_ACK = 1'b1;
        bus.iIR_READY = 1'b1;
        bus.iBR_TAKEN = 1'b1;
        bus.iPCBR     = 32'h80;
        tick();
        bus.iBR_TAKEN = 1'b0;
        bus.iIMEM_ACK = 1'b0;
        #1;
        nTests++; if (bus.oIR_VALID !== 1'b0) begin nFail++; $display("FAIL rap_flush_valid: got %b expected 0", bus.oIR_VALID); end
        nTests++; if (bus.oIMEM_REQ !== 1'b1 || bus.oIMEM_ADDR !== 8'h80) begin nFail++; $display("FAIL rap_target_req: got req=%b addr=%h expected req=1 addr=80", bus.oIMEM_REQ, bus.oIMEM_ADDR); end
        tick();
        nTests++; if (bus.oIR_VALID !== 1'b0) begin nFail++; $display("FAIL rap_no_push: got %b expected 0", bus.oIR_VALID); end
        bus.iIR_READY = 1'b0;
    endtask

    task automatic test_wrap();
        doReset();
        bus.iBR_TAKEN = 1'b1;
        bus.iPCBR     = 32'hFC;
        tick();
        bus.iBR_TAKEN = 1'b0;
        bus.iIMEM_ACK = 1'b1;
        bus.iIR_READY = 1'b1;
        #1;
        nTests++; if (bus.oIMEM_ADDR !== 8'hFC) begin nFail++; $display("FAIL wrap_addr_fc: got %h expected fc", bus.oIMEM_ADDR); end
        tick();
        nTests++; if (bus.oIR_PC !== 8'hFC) begin nFail++; $display("FAIL wrap_irpc_fc: got %h expected fc", bus.oIR_PC); end
        nTests++; if (bus.oIMEM_ADDR !== 8'h00) begin nFail++; $display("FAIL wrap_addr_00: got %h expected 00", bus.oIMEM_ADDR); end
        bus.iIMEM_ACK = 1'b0;
        bus.iBR_TAKEN = 1'b1;
        bus.iPCBR     = 32'h0001_0087;
        tick();
        bus.iBR_TAKEN = 1'b0;
        #1;
        nTests++; if (bus.oIMEM_ADDR !== 8'h84) begin nFail++; $display("FAIL wrap_target_84: got %h expected 84", bus.oIMEM_ADDR); end
        nTests++; if (bus.oIR_VALID !== 1'b0) begin nFail++; $display("FAIL wrap_flush_valid: got %b expected 0", bus.oIR_VALID); end
        bus.iIR_READY = 1'b0;
    endtask

    task automatic test_reset_mid();
        doReset();
        bus.iIMEM_ACK = 1'b1;
        #1;
        tick();
        bus.iIMEM_ACK = 1'b0;
        tick();
        nTests++; if (bus.oIMEM_REQ !== 1'b1 || bus.oIMEM_ADDR !== 8'h04 || bus.oIR_VALID !== 1'b1) begin nFail++; $display("FAIL rm_setup: got req=%b addr=%h valid=%b expected req=1 addr=04 valid=1", bus.oIMEM_REQ, bus.oIMEM_ADDR, bus.oIR_VALID); end
        rstN = 1'b0;
        #1;
        nTests++; if (bus.oIMEM_REQ !== 1'b0) begin nFail++; $display("FAIL rm_req: got %b expected 0", bus.oIMEM_REQ); end
        nTests++; if (bus.oIMEM_ADDR !== 8'h00) begin nFail++; $display("FAIL rm_addr: got %h expected 00", bus.oIMEM_ADDR); end
        nTests++; if (bus.oIR_VALID !== 1'b0 || bus.oIR !== 32'h0 || bus.oIR_PC !== 8'h00) begin nFail++; $display("FAIL rm_ir: got valid=%b ir=%h pc=%h expected 0/0/0", bus.oIR_VALID, bus.oIR, bus.oIR_PC); end
        tick();
        rstN = 1'b1;
        #1;
        nTests++; if (bus.oIMEM_REQ !== 1'b1 || bus.oIMEM_ADDR !== 8'h00) begin nFail++; $display("FAIL rm_restart: got req=%b addr=%h expected req=1 addr=00", bus.oIMEM_REQ, bus.oIMEM_ADDR); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch unit: owns the program counter, issues word reads to instruction memory and buffers returned instructions in a small FIFO for decode. It consumes the resolved branch target produced by the branch/jump resolution logic in the ALU stage. A redirect reloads the PC, flushes the buffer and discards any in-flight read. It sits between instruction memory and the decode/ALU stage and closes the PC loop that the branch resolver drives.

## Interface
- PC_W, 8, program-counter width in bits; the PC wraps modulo 2^PC_W
- RESET_PC, 0, PC value loaded at reset; bits [1:0] must be 0
- DEPTH, 2, instruction buffer entries; must be 2 or 4
- iCLK  in  1  clock; all state updates on the rising edge
- iRST_N  in  1  asynchronous, active-low reset
- iBR_TAKEN  in  1  redirect strobe, valid for one cycle
- iPCBR  in  32  redirect target; bits [PC_W-1:2] are used, bits [1:0] are ignored and treated as 0, upper bits are ignored
- oIMEM_REQ  out  1  read request to instruction memory
- oIMEM_ADDR  out  PC_W  read address, always word-aligned
- iIMEM_ACK  in  1  read complete; iIMEM_RDATA is valid in the same cycle
- iIMEM_RDATA  in  32  instruction word
- oIR_VALID  out  1  buffer head valid
- oIR  out  32  head instruction
- oIR_PC  out  PC_W  address of the head instruction
- iIR_READY  in  1  decode accepts the head instruction

## Operation
- FSM states:
  - S_FETCH: no read outstanding.
  - S_WAIT: read outstanding; its response is kept.
  - S_DROP: read outstanding; its response is discarded.
- Request rule: raise oIMEM_REQ in S_FETCH only when the buffer count is below DEPTH and iBR_TAKEN is low. Then go to S_WAIT.
  - oIMEM_REQ and oIMEM_ADDR stay stable until iIMEM_ACK is seen.
  - At most one read is outstanding.
- A request and its ACK may coincide in the same cycle (zero-wait memory). That read completes without leaving S_FETCH.
- ACK in S_WAIT, or in S_FETCH with the request raised:
  - push {iIMEM_RDATA, oIMEM_ADDR} into the buffer;
  - fetch PC <= fetch PC + 4, wrapping modulo 2^PC_W;
  - go to S_FETCH.
- ACK in S_DROP: discard the data, leave the PC unchanged, go to S_FETCH.
- Pop: when oIR_VALID && iIR_READY, advance the head.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push is legal at count == DEPTH if a pop occurs in the same cycle.
- Redirect (iBR_TAKEN = 1) takes priority over push, pop and PC increment:
  - fetch PC <= {iPCBR[PC_W-1:2], 2'b00};
  - buffer count <= 0, so oIR_VALID is low the next cycle;
  - S_WAIT with no ACK this cycle -> S_DROP;
  - S_WAIT with ACK this cycle, or S_FETCH -> S_FETCH, and any arriving data is discarded;
  - S_DROP stays in S_DROP unless ACK arrives this cycle, then -> S_FETCH.
- No request is issued in a redirect cycle. The first read of the target address goes out in the following cycle at the earliest.
- Back-to-back redirects: the last one wins.

## Timing
- Reset (asynchronous assert, synchronous release):
  - fetch PC = RESET_PC, state = S_FETCH, count = 0;
  - oIMEM_REQ = 0, oIMEM_ADDR = RESET_PC, oIR_VALID = 0, oIR = 0, oIR_PC = 0.
- First request: oIMEM_REQ goes high in the first cycle after reset deassertion.
- Latency: ACK at edge N makes oIR_VALID high after edge N, provided the buffer was empty.
- With zero-wait memory and iIR_READY held high, sustained throughput is 1 instruction per cycle.
- Redirect at edge N: oIMEM_ADDR = new target after edge N, or after the pending ACK if the state is S_DROP.
- Reset asserted mid-read: all state clears. A late ACK arriving after reset release while in S_FETCH with no request is ignored.
- oIR and oIR_PC are registered buffer outputs. No combinational path runs from iIMEM_RDATA to oIR.

## Structure
- Shared core package holds:
  - the FSM state encoding (S_FETCH = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2);
  - the instruction length constant ILEN_BYTES = 4;
  - the NOP encoding 32'h0000_0013, used by decode when oIR_VALID is low.
- One sub-module, ifetch_fifo: a DEPTH-entry FIFO with synchronous clear, push, pop, count, full and empty.
- The FSM and PC stay in instruction_fetch.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0013, iIR_READY = 1 -> addresses 0, 4, 8, 12 on consecutive cycles; oIR_PC follows one cycle behind.
- iIR_READY = 0, ACK every cycle, DEPTH = 2 -> two pushes, then oIMEM_REQ stays low. Raising iIR_READY resumes fetch at address 8.
- Read to address 0x10 outstanding with ACK delayed 3 cycles; iBR_TAKEN with iPCBR = 32'h40 in wait cycle 1:
  - the ACK data is discarded and oIR_VALID stays low;
  - the next request is to 0x40;
  - the first delivered oIR_PC is 0x40.
- Redirect in the same cycle as ACK and a pop -> buffer empty next cycle, no push, next request to target.
- PC_W = 8, PC = 0xFC, ACK -> next address is 0x00. iPCBR = 32'h1_0087 -> next address 0x84.
- Reset asserted while in S_WAIT -> all outputs at reset values immediately. After release the first request is to RESET_PC.
